mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory that serializes read/write requests and answers each
// one a fixed LATENCY cycles after acceptance, flagging misaligned or out-of-range accesses.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]       state;
  logic [3:0]       count;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH];
  logic             accept;
  logic             finish;
  logic             bad_addr;
  logic [IDX_W-1:0] word_idx;

  // The edge leaving RESP may already accept the next request, giving one
  // request per LATENCY+1 cycles under a continuously held req.
  assign accept   = req && ((state == IDLE) || (state == RESP));
  assign finish   = (state == WAIT) && (count == 4'd0);
  assign word_idx = addr_q[IDX_W+1:2];
  assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[31:IDX_W+2] != '0);

  assign busy = (state != IDLE);
  assign done = (state == RESP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            count <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (req) begin
            state <= WAIT;
            count <= CNT_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      wr_q    <= wr;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Response registers: err lives only for the RESP cycle, rdata only moves on reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err   <= 1'b0;
      rdata <= 32'h0;
    end else if (finish) begin
      err <= bad_addr;
      if (!wr_q) begin
        rdata <= bad_addr ? 32'h0 : mem[word_idx];
      end
    end else if (state == RESP) begin
      err <= 1'b0;
    end
  end

  // Storage is deliberately outside reset; an aborted request never reaches finish.
  always_ff @(posedge clock) begin
    if (finish && wr_q && !bad_addr) begin
      mem[word_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: three instances (LATENCY 2, 1, 15)
// compared against a word-array reference model kept in the bench.
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic [2:0]  rst_s;
  logic [2:0]  req_s;
  logic [2:0]  wr_s;
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [2:0]  busy_s;
  logic [2:0]  done_s;
  logic [31:0] rdata_s [3];
  logic [2:0]  err_s;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [3][DEPTH];
  logic [31:0] rd_model [3];

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clock(clock), .reset(rst_s[0]), .req(req_s[0]), .wr(wr_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .rdata(rdata_s[0]), .err(err_s[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .clock(clock), .reset(rst_s[1]), .req(req_s[1]), .wr(wr_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .rdata(rdata_s[1]), .err(err_s[1])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut_c (
    .clock(clock), .reset(rst_s[2]), .req(req_s[2]), .wr(wr_s[2]),
    .addr(addr_s[2]), .wdata(wdata_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .rdata(rdata_s[2]), .err(err_s[2])
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One request on instance d, back-to-back with whatever preceded it; optionally
  // pokes a conflicting write request while the first one is waiting.
  task automatic apply_stimulus(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input bit poke);
    logic        exp_err;
    int          n;
    int          lat;
    bit          seen;
    lat     = lat_of(d);
    exp_err = (a % 4 != 0) || ((a / 4) >= DEPTH);
    req_s[d]   = 1'b1;
    wr_s[d]    = w;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    @(posedge clock); #1;
    req_s[d]   = 1'b0;
    wr_s[d]    = 1'($urandom);
    addr_s[d]  = $urandom;
    wdata_s[d] = $urandom;
    check_output("accept_busy", {31'b0, busy_s[d]}, 32'd1);
    check_output("accept_done", {31'b0, done_s[d]}, 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (poke && n == 2) begin
        req_s[d]   = 1'b1;
        wr_s[d]    = 1'b1;
        addr_s[d]  = a ^ 32'h60;
        wdata_s[d] = ~wd;
      end
      if (poke && n == 4) req_s[d] = 1'b0;
      @(posedge clock); #1;
      n++;
      seen = done_s[d];
      if (!seen) check_output("wait_busy", {31'b0, busy_s[d]}, 32'd1);
    end
    check_output("latency", n, lat);
    if (w && !exp_err) mem_m[d][a / 4] = wd;
    if (!w) rd_model[d] = exp_err ? 32'h0 : mem_m[d][a / 4];
    check_output("resp_busy", {31'b0, busy_s[d]}, 32'd1);
    check_output("resp_err", {31'b0, err_s[d]}, {31'b0, exp_err});
    check_output("resp_rdata", rdata_s[d], rd_model[d]);
  endtask

  task automatic idle_cycles(input int d, input int k);
    req_s[d] = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #1;
      check_output("idle_busy", {31'b0, busy_s[d]}, 32'd0);
      check_output("idle_done", {31'b0, done_s[d]}, 32'd0);
      check_output("idle_err", {31'b0, err_s[d]}, 32'd0);
      check_output("idle_rdata", rdata_s[d], rd_model[d]);
    end
  endtask

  logic [31:0] items_a [8];
  logic [31:0] items_d [8];
  logic        items_w [8];

  initial begin
    logic [31:0] ra;
    logic [31:0] d1;
    logic [31:0] d2;
    int          k;
    int          cat;

    rst_s = 3'b000;
    req_s = 3'b000;
    wr_s  = 3'b000;
    for (int d = 0; d < 3; d++) begin
      addr_s[d]   = 32'h0;
      wdata_s[d]  = 32'h0;
      rd_model[d] = 32'h0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      check_output("rst_busy", {31'b0, busy_s[d]}, 32'd0);
      check_output("rst_done", {31'b0, done_s[d]}, 32'd0);
      check_output("rst_err", {31'b0, err_s[d]}, 32'd0);
      check_output("rst_rdata", rdata_s[d], 32'h0);
    end
    @(negedge clock);
    rst_s = 3'b111;

    $display("[TB] filling storage of instance A");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 1'b1, 32'(i * 4), $urandom, 1'b0);
    idle_cycles(0, 2);

    $display("[TB] directed write/read, misaligned and range cases");
    apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);
    check_output("dir_rdata_10", rdata_s[0], 32'hDEADBEEF);
    apply_stimulus(0, 1'b0, 32'h13, 32'h0, 1'b0);
    apply_stimulus(0, 1'b1, 32'h13, 32'h12345678, 1'b0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);
    apply_stimulus(0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0);
    apply_stimulus(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0);
    apply_stimulus(0, 1'b0, 32'h3FC, 32'h0, 1'b0);
    apply_stimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle_cycles(0, 3);

    $display("[TB] reset during a pending write");
    req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = 32'h0BADF00D;
    @(posedge clock); #1;
    req_s[0] = 1'b0;
    @(posedge clock); #1;
    rst_s[0] = 1'b0;
    #1;
    check_output("abort_busy", {31'b0, busy_s[0]}, 32'd0);
    check_output("abort_done", {31'b0, done_s[0]}, 32'd0);
    check_output("abort_rdata", rdata_s[0], 32'h0);
    rd_model[0] = 32'h0;
    @(posedge clock);
    @(negedge clock);
    rst_s[0] = 1'b1;
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);
    idle_cycles(0, 1);

    $display("[TB] random traffic on instance A");
    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 9);
      if (cat == 0)      ra = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
      else if (cat == 1) ra = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      else               ra = $urandom_range(0, DEPTH - 1) * 4;
      apply_stimulus(0, 1'($urandom), ra, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycles(0, $urandom_range(1, 3));
    end
    idle_cycles(0, 1);

    $display("[TB] continuous req on instance B");
    for (int i = 0; i < 4; i++) begin
      items_a[i]     = 32'(i * 4 + 32'h40);
      items_d[i]     = $urandom;
      items_w[i]     = 1'b1;
      items_a[i + 4] = items_a[i];
      items_d[i + 4] = 32'h0;
      items_w[i + 4] = 1'b0;
    end
    req_s[1] = 1'b1; wr_s[1] = items_w[0]; addr_s[1] = items_a[0]; wdata_s[1] = items_d[0];
    for (int e = 0; e < 16; e++) begin
      @(posedge clock); #1;
      check_output("cont_busy", {31'b0, busy_s[1]}, 32'd1);
      check_output("cont_done", {31'b0, done_s[1]}, {31'b0, (e % 2) == 1});
      if (e % 2 == 0) begin
        k = e / 2 + 1;
        if (k < 8) begin
          wr_s[1] = items_w[k]; addr_s[1] = items_a[k]; wdata_s[1] = items_d[k];
        end else begin
          req_s[1] = 1'b0;
        end
      end else if (!items_w[(e - 1) / 2]) begin
        check_output("cont_rdata", rdata_s[1], items_d[(e - 1) / 2 - 4]);
      end
    end
    @(posedge clock); #1;
    check_output("cont_end_busy", {31'b0, busy_s[1]}, 32'd0);

    $display("[TB] ignored req during long wait on instance C");
    d1 = $urandom;
    d2 = $urandom;
    apply_stimulus(2, 1'b1, 32'h20, d1, 1'b0);
    apply_stimulus(2, 1'b1, 32'h40, d2, 1'b0);
    apply_stimulus(2, 1'b0, 32'h20, 32'h0, 1'b1);
    apply_stimulus(2, 1'b0, 32'h40, 32'h0, 1'b0);
    idle_cycles(2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
